// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch front end: entry layout and fetch FSM states.
package fetch_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_W    = 64;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    typedef enum logic { RUN, DROP } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead synchronous FIFO holding fetched {pc, instr} entries.
// Storage resets to zero so the head outputs read zero out of reset.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = $bits(fetch_entry_t)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    input  logic                   clear,
    output logic [$clog2(DEPTH):0] count,
    output logic [W-1:0]           head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_prefetch.sv
// Fetch front end: owns the fetch PC, issues one-word reads with FIFO credit reservation,
// and flushes/refetches on a branch redirect.
module instr_prefetch #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PC_W  = fetch_pkg::PC_W
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            out_valid,
    output logic [31:0]     out_instr,
    output logic [PC_W-1:0] out_pc,
    input  logic            out_ready
);

    import fetch_pkg::*;

    localparam int unsigned EW = PC_W + INSTR_W;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_L = (CW + 1)'(DEPTH);

    fetch_state_t    state;
    logic [PC_W-1:0] fetch_pc;
    logic [PC_W-1:0] req_pc;
    logic            inflight;

    logic [CW-1:0]   count;
    logic [CW:0]     used;
    logic [EW-1:0]   head;
    logic            push;
    logic            pop;

    // Credits are reserved at request time; same-cycle pops are deliberately not counted.
    assign used     = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign imem_req = rst && (state == RUN) && !redirect && (used < DEPTH_L);
    assign imem_addr = fetch_pc;

    assign push      = inflight && (state == RUN) && !redirect;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready && !redirect;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            fetch_pc <= '0;
            req_pc   <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                req_pc <= fetch_pc;
            end
            if (redirect) begin
                fetch_pc <= {redirect_pc[PC_W-1:2], 2'b00};
                state    <= inflight ? DROP : RUN;
            end else begin
                if (imem_req) begin
                    fetch_pc <= fetch_pc + PC_W'(4);
                end
                state <= RUN;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({req_pc, imem_rdata}),
        .pop       (pop),
        .clear     (redirect),
        .count     (count),
        .head      (head)
    );

    assign out_pc    = head[EW-1 -: PC_W];
    assign out_instr = head[INSTR_W-1:0];

endmodule
